sram_arb2: RTL and testbench
============================

// Module: sram_arb2
// PURPOSE
//   Two-requester arbiter for the single-port byte-write-enable SRAM. It shares one
//   SRAM port between master 0 (APB side) and master 1 (DMA/init side).
//   Each master gets a valid/ready request channel and a read-response channel.
//   Arbitration is round-robin with bounded burst ownership.
//   Sits directly in front of the SRAM macro; one access per cycle, no bubbles.
// PARAMETERS
//   ADDR_WIDTH  10  SRAM word-address width
//   DATA_WIDTH  32  SRAM data width; fixed at 32 (4 byte lanes)
//   MAX_BURST   4   max consecutive beats one master keeps the port while the other waits; legal 1..16
// PORTS
//   clk_i         in   1           clock, all logic on rising edge
//   rst_i         in   1           synchronous reset, active-high
//   mN_valid_i    in   1           N=0,1: request valid
//   mN_ready_o    out  1           request accepted this cycle (valid&ready = beat)
//   mN_we_i       in   1           1=write, 0=read
//   mN_wbe_i      in   4           byte write enables, bit k -> bits [8k+7:8k]
//   mN_addr_i     in   ADDR_WIDTH  word address
//   mN_wdata_i    in   DATA_WIDTH  write data
//   mN_rvalid_o   out  1           read data valid for master N
//   mN_rdata_o    out  DATA_WIDTH  read data (= sram_rdata_i)
//   sram_en_o     out  1           SRAM enable
//   sram_we_o     out  1           SRAM write enable
//   sram_wbe_o    out  4           SRAM byte enables
//   sram_addr_o   out  ADDR_WIDTH  SRAM address
//   sram_wdata_o  out  DATA_WIDTH  SRAM write data
//   sram_rdata_i  in   DATA_WIDTH  SRAM read data, registered, valid 1 cycle after read issue
// BEHAVIOUR
//   - State: own (IDLE/OWN0/OWN1), beat_cnt (0..MAX_BURST, saturating), rr_last (last served port).
//   - Reset (rst_i=1 at edge): own=IDLE, beat_cnt=0, rr_last=1 (port 0 wins first tie), m*_rvalid_o=0.
//     While rst_i=1: m*_ready_o=0, sram_en_o=0.
//   - Select (combinational, same cycle), with x = owner and y = the other port:
//     IDLE: only one valid -> that port; both valid -> port != rr_last; none -> no grant.
//     OWNx: grant x if mx_valid and not (beat_cnt==MAX_BURST and my_valid); else y if my_valid; else none.
//   - Granted port: mS_ready_o=1 and SRAM outputs are driven from its request.
//     sram_en_o=1. sram_we_o/wbe_o/addr_o/wdata_o = mS_*. Non-granted ready_o=0.
//   - No grant: sram_en_o=0 and the other SRAM outputs are 0.
//   - Next state on grant S: own=OWNS, rr_last=S. beat_cnt = (S==owner) ? sat(beat_cnt+1) : 1.
//     No grant: own=IDLE, beat_cnt=0, rr_last unchanged.
//   - Owner alone and valid keeps the port indefinitely; beat_cnt saturates at MAX_BURST.
//   - Owner drops valid: the other port is granted in that same cycle if valid (no dead cycle).
//   - Read: mN_rvalid_o=1 exactly one cycle after an accepted read beat from N.
//     Back-to-back reads give back-to-back rvalid. Responses cannot be stalled.
//   - Write: no response. wbe=4'b0000 still issues an SRAM write cycle, which changes no memory.
//   - A write then a read to the same address on consecutive cycles returns the new data.
//   - Masters hold we/wbe/addr/wdata stable while valid & !ready. The arbiter does not check this.
//   - Reset mid-operation: a pending rvalid is dropped and no response is produced for it.
//     Arbitration restarts with port 0 priority.
//   - m0_rdata_o and m1_rdata_o are both wired to sram_rdata_i. Their contents are meaningful only with rvalid.
// TESTING
//   1 Reset, then m0 read addr 0x005 alone -> m0_ready_o=1 and sram_en_o=1, sram_we_o=0, addr 0x005 the same cycle.
//     m0_rvalid_o=1 next cycle.
//   2 Both masters valid, continuous, MAX_BURST=4 -> grants 0,0,0,0,1,1,1,1,0,...
//     sram_en_o=1 every cycle, no idle cycle.
//   3 Both masters valid in IDLE after reset -> m0 granted first.
//     Idle 1 cycle, then both valid again -> the port other than the last served is granted.
//   4 m1 writes 0xAABBCCDD to 0x010 with wbe=1111. m1 then writes 0x11223344 to 0x010 with wbe=0101.
//     m0 then reads 0x010 -> 0xAA22CC44 returned with m0_rvalid_o one cycle after accept.
//   5 m1 alone valid for 10 cycles -> 10 consecutive grants, beat_cnt saturates at 4.
//     m0 becomes valid -> m0 granted that same cycle.
//   6 m0 read accepted, rst_i=1 the next cycle -> m0_rvalid_o=0, ready_o=0, sram_en_o=0.
//     After release: own=IDLE, port 0 wins the first tie.

Source files
------------

// File: rtl/sram_arb2.sv
// ---------------------------------------------------------------------------
// sram_arb2 -- two-master arbiter in front of a single-port SRAM.
//
// Shares one SRAM port with byte write enables between master 0 (APB side)
// and master 1 (DMA/init side). Arbitration is round-robin. A master keeps
// the port for consecutive beats, but after MAX_BURST beats it must yield
// if the other master is waiting. Grants are combinational, so the port
// never idles while a request is pending.
//
// Ports
//   clk_i, rst_i                 clock; synchronous active-high reset
//   mN_valid_i / mN_ready_o      request handshake (beat = valid & ready)
//   mN_we_i, mN_wbe_i            1=write; byte enable k covers bits [8k+7:8k]
//   mN_addr_i, mN_wdata_i        word address, write data
//   mN_rvalid_o, mN_rdata_o      read response, one cycle after an accepted read
//   sram_en_o .. sram_wdata_o    SRAM request (all zero when nothing is granted)
//   sram_rdata_i                 SRAM registered read data
// ---------------------------------------------------------------------------
module sram_arb2 #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_valid_i,
  output logic                  m0_ready_o,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_wbe_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_valid_i,
  output logic                  m1_ready_o,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_wbe_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  sram_en_o,
  output logic                  sram_we_o,
  output logic [3:0]            sram_wbe_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} own_t;

  own_t          r_own;
  own_t          w_own_next;
  logic [CW-1:0] r_beat_cnt;
  logic [CW-1:0] w_beat_next;
  logic [CW-1:0] w_beat_inc;
  logic          r_rr_last;
  logic          w_rr_next;
  logic [1:0]    r_rvalid;
  logic [1:0]    w_gnt;
  logic          w_sat;

  assign w_sat      = (r_beat_cnt == CW'(MAX_BURST));
  // Saturating increment: an unopposed owner may run forever.
  assign w_beat_inc = w_sat ? r_beat_cnt : r_beat_cnt + CW'(1);

  // Grant selection. Reset blocks every grant so the SRAM sees no access.
  always_comb begin
    w_gnt = 2'b00;
    if (!rst_i) begin
      case (r_own)
        IDLE: begin
          if (m0_valid_i && m1_valid_i)
            w_gnt = r_rr_last ? 2'b01 : 2'b10;
          else
            w_gnt = {m1_valid_i, m0_valid_i};
        end
        OWN0: begin
          if (m0_valid_i && !(w_sat && m1_valid_i)) w_gnt = 2'b01;
          else if (m1_valid_i)                      w_gnt = 2'b10;
        end
        OWN1: begin
          if (m1_valid_i && !(w_sat && m0_valid_i)) w_gnt = 2'b10;
          else if (m0_valid_i)                      w_gnt = 2'b01;
        end
        default: w_gnt = 2'b00;
      endcase
    end
  end

  // Next-state: a grant to the current owner extends its burst, a grant to
  // the other port starts a fresh burst at one beat.
  always_comb begin
    w_own_next  = IDLE;
    w_beat_next = '0;
    w_rr_next   = r_rr_last;
    if (w_gnt[0]) begin
      w_own_next  = OWN0;
      w_rr_next   = 1'b0;
      w_beat_next = (r_own == OWN0) ? w_beat_inc : CW'(1);
    end else if (w_gnt[1]) begin
      w_own_next  = OWN1;
      w_rr_next   = 1'b1;
      w_beat_next = (r_own == OWN1) ? w_beat_inc : CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_own      <= IDLE;
      r_beat_cnt <= '0;
      r_rr_last  <= 1'b1;   // port 0 wins the first tie
      r_rvalid   <= 2'b00;
    end else begin
      r_own      <= w_own_next;
      r_beat_cnt <= w_beat_next;
      r_rr_last  <= w_rr_next;
      r_rvalid   <= {w_gnt[1] & ~m1_we_i, w_gnt[0] & ~m0_we_i};
    end
  end

  assign m0_ready_o = w_gnt[0];
  assign m1_ready_o = w_gnt[1];

  // A response whose cycle coincides with reset is dropped.
  assign m0_rvalid_o = r_rvalid[0] & ~rst_i;
  assign m1_rvalid_o = r_rvalid[1] & ~rst_i;
  assign m0_rdata_o  = sram_rdata_i;
  assign m1_rdata_o  = sram_rdata_i;

  always_comb begin
    sram_en_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_wbe_o   = 4'b0000;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (w_gnt[0]) begin
      sram_en_o    = 1'b1;
      sram_we_o    = m0_we_i;
      sram_wbe_o   = m0_wbe_i;
      sram_addr_o  = m0_addr_i;
      sram_wdata_o = m0_wdata_i;
    end else if (w_gnt[1]) begin
      sram_en_o    = 1'b1;
      sram_we_o    = m1_we_i;
      sram_wbe_o   = m1_wbe_i;
      sram_addr_o  = m1_addr_i;
      sram_wdata_o = m1_wdata_i;
    end
  end

endmodule

// File: tb/tb_sram_arb2.sv
// ---------------------------------------------------------------------------
// tb_sram_arb2 -- directed self-checking bench for sram_arb2.
// A small behavioural SRAM (byte enables, registered read) sits on the
// SRAM port. Inputs change 1 ns after the rising edge; outputs are checked
// 1 ns after that, well before the next edge.
// ---------------------------------------------------------------------------
module tb_sram_arb2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m0_ready, m0_we, m0_rvalid;
  logic [3:0]  m0_wbe;
  logic [9:0]  m0_addr;
  logic [31:0] m0_wdata, m0_rdata;
  logic        m1_valid, m1_ready, m1_we, m1_rvalid;
  logic [3:0]  m1_wbe;
  logic [9:0]  m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic        sram_en, sram_we;
  logic [3:0]  sram_wbe;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  sram_arb2 #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_valid_i(m0_valid), .m0_ready_o(m0_ready), .m0_we_i(m0_we), .m0_wbe_i(m0_wbe),
    .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_valid_i(m1_valid), .m1_ready_o(m1_ready), .m1_we_i(m1_we), .m1_wbe_i(m1_wbe),
    .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_wbe_o(sram_wbe),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
  );

  // Behavioural SRAM macro.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        for (int k = 0; k < 4; k++)
          if (sram_wbe[k]) mem[sram_addr][8*k +: 8] <= sram_wdata[8*k +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic we, input logic [3:0] wbe,
                        input logic [9:0] addr, input logic [31:0] wd);
    m0_valid = v; m0_we = we; m0_wbe = wbe; m0_addr = addr; m0_wdata = wd;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [3:0] wbe,
                        input logic [9:0] addr, input logic [31:0] wd);
    m1_valid = v; m1_we = we; m1_wbe = wbe; m1_addr = addr; m1_wdata = wd;
  endtask

  task automatic do_reset();
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reset state: with both masters requesting, nothing is granted.
  task automatic test_reset();
    rst = 1'b1;
    drive0(1, 0, 4'h0, 10'h001, 0);
    drive1(1, 0, 4'h0, 10'h002, 0);
    tick();
    tick();
    #1;
    n_cmp++;
    if ({m0_ready, m1_ready, sram_en, m0_rvalid, m1_rvalid} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy0=%b rdy1=%b en=%b rv0=%b rv1=%b, want all 0",
               m0_ready, m1_ready, sram_en, m0_rvalid, m1_rvalid);
    end
    n_cmp++;
    if ({sram_we, sram_wbe, sram_addr, sram_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_sram_zero: got we=%b wbe=%h addr=%h wd=%h, want 0",
               sram_we, sram_wbe, sram_addr, sram_wdata);
    end
    $display("reset: outputs idle while rst=1");
    do_reset();
  endtask

  // Lone m0 read: granted the same cycle, response the next.
  task automatic test_single_read();
    drive0(1, 0, 4'hF, 10'h005, 32'h0);
    #1;
    n_cmp++;
    if ({m0_ready, m1_ready, sram_en, sram_we} !== 4'b1010 || sram_addr !== 10'h005) begin
      n_err++;
      $display("FAIL single_read_grant: got rdy0=%b rdy1=%b en=%b we=%b addr=%h, want 1 0 1 0 005",
               m0_ready, m1_ready, sram_en, sram_we, sram_addr);
    end
    tick();
    drive0(0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== 32'hC0DE0005) begin
      n_err++;
      $display("FAIL single_read_resp: got rv0=%b rv1=%b rdata=%h, want 1 0 c0de0005",
               m0_rvalid, m1_rvalid, m0_rdata);
    end
    $display("single_read: m0 read 0x005 -> %h", m0_rdata);
    tick();
    n_cmp++;
    if (m0_rvalid !== 1'b0 || sram_en !== 1'b0) begin
      n_err++;
      $display("FAIL single_read_quiet: got rv0=%b en=%b, want 0 0", m0_rvalid, sram_en);
    end
  endtask

  // Both masters continuously valid: bursts of four, alternating.
  task automatic test_burst_rr();
    logic [9:0] exp_seq;
    logic       prev_g0;
    exp_seq = 10'b0011110000;   // bit i = 1 means port 1 granted in cycle i
    do_reset();
    drive0(1, 0, 4'hF, 10'h020, 0);
    drive1(1, 0, 4'hF, 10'h030, 0);
    prev_g0 = 1'bx;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++;
      if (m1_ready !== exp_seq[i] || m0_ready !== ~exp_seq[i] || sram_en !== 1'b1 ||
          sram_addr !== (exp_seq[i] ? 10'h030 : 10'h020)) begin
        n_err++;
        $display("FAIL burst_rr cycle %0d: got rdy0=%b rdy1=%b en=%b addr=%h, want port %0d",
                 i, m0_ready, m1_ready, sram_en, sram_addr, exp_seq[i]);
      end
      if (i > 0) begin
        n_cmp++;
        if (m0_rvalid !== prev_g0 || m1_rvalid !== ~prev_g0) begin
          n_err++;
          $display("FAIL burst_rvalid cycle %0d: got rv0=%b rv1=%b, want rv0=%b",
                   i, m0_rvalid, m1_rvalid, prev_g0);
        end
      end
      $display("burst_rr: cycle %0d granted port %0d", i, m1_ready);
      prev_g0 = ~exp_seq[i];
      tick();
    end
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    tick();
  endtask

  // Tie in IDLE: port 0 after reset, then the port not served last.
  task automatic test_idle_rr();
    do_reset();
    drive0(1, 0, 4'hF, 10'h040, 0);
    drive1(1, 0, 4'hF, 10'h041, 0);
    #1;
    n_cmp++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL idle_rr_first: got rdy0=%b rdy1=%b, want 1 0", m0_ready, m1_ready);
    end
    tick();
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (sram_en !== 1'b0 || sram_addr !== 10'h0) begin
      n_err++;
      $display("FAIL idle_rr_gap: got en=%b addr=%h, want 0 000", sram_en, sram_addr);
    end
    tick();
    drive0(1, 0, 4'hF, 10'h040, 0);
    drive1(1, 0, 4'hF, 10'h041, 0);
    #1;
    n_cmp++;
    if (m0_ready !== 1'b0 || m1_ready !== 1'b1 || sram_addr !== 10'h041) begin
      n_err++;
      $display("FAIL idle_rr_second: got rdy0=%b rdy1=%b addr=%h, want 0 1 041",
               m0_ready, m1_ready, sram_addr);
    end
    $display("idle_rr: first tie -> m0, after idle -> m1");
    tick();
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    tick();
  endtask

  // Byte-enable merge, zero-enable write, write-then-read forwarding.
  task automatic test_write_merge();
    drive1(1, 1, 4'b1111, 10'h010, 32'hAABBCCDD);
    #1;
    n_cmp++;
    if (m1_ready !== 1'b1 || sram_we !== 1'b1 || sram_wbe !== 4'b1111 || sram_wdata !== 32'hAABBCCDD) begin
      n_err++;
      $display("FAIL write_full: got rdy1=%b we=%b wbe=%b wd=%h, want 1 1 1111 aabbccdd",
               m1_ready, sram_we, sram_wbe, sram_wdata);
    end
    tick();
    drive1(1, 1, 4'b0101, 10'h010, 32'h11223344);
    tick();
    drive1(0, 0, 0, 0, 0);
    drive0(1, 0, 4'hF, 10'h010, 0);
    #1;
    n_cmp++;
    if (m0_ready !== 1'b1 || m1_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL merge_read_grant: got rdy0=%b rv1=%b, want 1 0", m0_ready, m1_rvalid);
    end
    tick();
    drive0(0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hAA22CC44) begin
      n_err++;
      $display("FAIL merge_read_data: got rv0=%b rdata=%h, want 1 aa22cc44", m0_rvalid, m0_rdata);
    end
    $display("write_merge: read 0x010 -> %h", m0_rdata);
    // Zero byte enables: a write cycle is issued but memory is unchanged.
    drive1(1, 1, 4'b0000, 10'h010, 32'hFFFFFFFF);
    #1;
    n_cmp++;
    if (sram_en !== 1'b1 || sram_we !== 1'b1 || sram_wbe !== 4'b0000) begin
      n_err++;
      $display("FAIL wbe_zero_cycle: got en=%b we=%b wbe=%b, want 1 1 0000", sram_en, sram_we, sram_wbe);
    end
    tick();
    drive1(0, 0, 0, 0, 0);
    drive0(1, 0, 4'hF, 10'h010, 0);
    tick();
    drive0(0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hAA22CC44) begin
      n_err++;
      $display("FAIL wbe_zero_data: got rv0=%b rdata=%h, want 1 aa22cc44", m0_rvalid, m0_rdata);
    end
    $display("write_merge: wbe=0 write leaves %h", m0_rdata);
    tick();
  endtask

  // Lone m1 keeps the port; m0 arriving after saturation wins at once.
  task automatic test_m1_alone();
    do_reset();
    drive1(1, 0, 4'hF, 10'h060, 0);
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++;
      if (m1_ready !== 1'b1 || m0_ready !== 1'b0 || (i > 0 && m1_rvalid !== 1'b1)) begin
        n_err++;
        $display("FAIL m1_alone cycle %0d: got rdy1=%b rdy0=%b rv1=%b, want 1 0 1",
                 i, m1_ready, m0_ready, m1_rvalid);
      end
      tick();
    end
    $display("m1_alone: 10 consecutive grants to m1");
    drive0(1, 0, 4'hF, 10'h061, 0);
    #1;
    n_cmp++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || sram_addr !== 10'h061) begin
      n_err++;
      $display("FAIL m1_alone_handover: got rdy0=%b rdy1=%b addr=%h, want 1 0 061",
               m0_ready, m1_ready, sram_addr);
    end
    tick();
    #1;
    n_cmp++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL m1_alone_newburst: got rdy0=%b rdy1=%b, want 1 0", m0_ready, m1_ready);
    end
    $display("m1_alone: m0 granted on arrival and keeps its fresh burst");
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    tick();
  endtask

  // Reset right after an accepted read drops the response.
  task automatic test_reset_mid();
    do_reset();
    drive1(1, 0, 4'hF, 10'h070, 0);
    tick();                       // m1 served last, so rr state favours m0 anyway
    drive1(0, 0, 0, 0, 0);
    drive0(1, 0, 4'hF, 10'h071, 0);
    #1;
    n_cmp++;
    if (m0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_accept: got rdy0=%b, want 1", m0_ready);
    end
    tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (m0_rvalid !== 1'b0 || m0_ready !== 1'b0 || sram_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_drop: got rv0=%b rdy0=%b en=%b, want 0 0 0", m0_rvalid, m0_ready, sram_en);
    end
    tick();
    rst = 1'b0;
    drive1(1, 0, 4'hF, 10'h072, 0);
    #1;
    n_cmp++;
    if (m0_rvalid !== 1'b0 || m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_restart: got rv0=%b rdy0=%b rdy1=%b, want 0 1 0",
               m0_rvalid, m0_ready, m1_ready);
    end
    $display("reset_mid: response dropped, m0 wins first tie after release");
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | i;
    sram_rdata = '0;
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    test_reset();
    test_single_read();
    test_burst_rr();
    test_idle_rr();
    test_write_merge();
    test_m1_alone();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
